// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry, RGB565 pixel layout, bank FSM states
// and the integer luma weighting used by the read path and the binarizer.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 320;
  localparam int unsigned FB_HEIGHT = 240;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;

  localparam logic [15:0] LUMA_R = 16'd77;
  localparam logic [15:0] LUMA_G = 16'd150;
  localparam logic [15:0] LUMA_B = 16'd29;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef enum logic [1:0] {
    EMPTY,
    DISPLAY,
    PENDING
  } bank_state_t;

  // Weights sum to 256, so a full-scale pixel lands exactly on 255.
  function automatic logic [7:0] rgb565_luma(input rgb565_t px);
    logic [15:0] r8;
    logic [15:0] g8;
    logic [15:0] b8;
    logic [15:0] acc;
    r8  = {8'd0, px.r, px.r[4:2]};
    g8  = {8'd0, px.g, px.g[5:4]};
    b8  = {8'd0, px.b, px.b[4:2]};
    acc = LUMA_R * r8 + LUMA_G * g8 + LUMA_B * b8;
    return acc[15:8];
  endfunction

endpackage

// File: rtl/rgb565_to_luma.sv
// Registered RGB565 -> 8-bit luma converter with binary threshold; outputs hold
// between loads and can be forced to zero for blanked words.
module rgb565_to_luma
  import fb_pkg::*;
#(
  parameter logic [7:0] THRESHOLD = 8'd128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic        blank_in,
  input  logic [15:0] rgb_in,
  output logic [15:0] pixel_out,
  output logic [7:0]  luma_out,
  output logic        bw_out
);

  logic [7:0] luma_c;

  always_comb begin
    luma_c = rgb565_luma(rgb565_t'(rgb_in));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_out <= '0;
      luma_out  <= '0;
      bw_out    <= 1'b0;
    end else if (load_in) begin
      if (blank_in) begin
        pixel_out <= '0;
        luma_out  <= '0;
        bw_out    <= 1'b0;
      end else begin
        pixel_out <= rgb_in;
        luma_out  <= luma_c;
        bw_out    <= (luma_c >= THRESHOLD);
      end
    end
  end

endmodule

// File: rtl/frame_buffer_reader.sv
// Read side of the double-buffered 320x240 RGB565 frame buffer: bank arbitration
// with the camera writer, BRAM read addressing, latency alignment and luma/BW output.
module frame_buffer_reader #(
  parameter int unsigned FB_DEPTH     = fb_pkg::FB_DEPTH,
  parameter int unsigned BRAM_LATENCY = 2,
  parameter logic [7:0]  BW_THRESHOLD = 8'd128
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [16:0] pixel_addr_in,
  input  logic        valid_addr_in,
  input  logic        frame_start_in,
  input  logic        write_frame_done_in,
  output logic        write_bank_out,
  output logic        write_hold_out,
  output logic [17:0] bram_addr_out,
  input  logic [15:0] bram_rdata_in,
  output logic [15:0] pixel_out,
  output logic [7:0]  luma_out,
  output logic        bw_out,
  output logic        valid_pixel_out,
  output logic        frame_ready_out
);

  import fb_pkg::*;

  localparam logic [16:0] DEPTH_LIMIT = 17'(FB_DEPTH);

  bank_state_t state_q, state_d;
  logic        read_bank_q, read_bank_d;
  logic        write_bank_q, write_bank_d;
  logic        ready_q, ready_d;

  always_comb begin
    state_d      = state_q;
    read_bank_d  = read_bank_q;
    write_bank_d = write_bank_q;
    ready_d      = ready_q;
    case (state_q)
      EMPTY, DISPLAY: begin
        if (write_frame_done_in) state_d = PENDING;
      end
      PENDING: begin
        // A done pulse here is a writer protocol error and is ignored.
        if (frame_start_in) begin
          state_d      = DISPLAY;
          read_bank_d  = write_bank_q;
          write_bank_d = ~write_bank_q;
          ready_d      = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= EMPTY;
      read_bank_q  <= 1'b0;
      write_bank_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      read_bank_q  <= read_bank_d;
      write_bank_q <= write_bank_d;
      ready_q      <= ready_d;
    end
  end

  assign write_hold_out  = (state_q == PENDING);
  assign write_bank_out  = write_bank_q;
  assign frame_ready_out = ready_q;

  logic addr_valid_q, addr_in_range_q, addr_ready_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      bram_addr_out   <= '0;
      addr_valid_q    <= 1'b0;
      addr_in_range_q <= 1'b0;
      addr_ready_q    <= 1'b0;
    end else begin
      addr_valid_q    <= valid_addr_in;
      addr_in_range_q <= (pixel_addr_in < DEPTH_LIMIT);
      addr_ready_q    <= ready_q;
      if (valid_addr_in) bram_addr_out <= {read_bank_q, pixel_addr_in};
    end
  end

  logic [BRAM_LATENCY-1:0] pipe_valid_q, pipe_in_range_q, pipe_ready_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pipe_valid_q    <= '0;
      pipe_in_range_q <= '0;
      pipe_ready_q    <= '0;
    end else begin
      pipe_valid_q[0]    <= addr_valid_q;
      pipe_in_range_q[0] <= addr_in_range_q;
      pipe_ready_q[0]    <= addr_ready_q;
      for (int unsigned i = 1; i < BRAM_LATENCY; i++) begin
        pipe_valid_q[i]    <= pipe_valid_q[i-1];
        pipe_in_range_q[i] <= pipe_in_range_q[i-1];
        pipe_ready_q[i]    <= pipe_ready_q[i-1];
      end
    end
  end

  logic word_valid, word_blank;

  // Blank until a first completed frame has been selected for display.
  assign word_valid = pipe_valid_q[BRAM_LATENCY-1];
  assign word_blank = !pipe_in_range_q[BRAM_LATENCY-1] || !pipe_ready_q[BRAM_LATENCY-1];

  rgb565_to_luma #(
    .THRESHOLD(BW_THRESHOLD)
  ) u_luma (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .load_in  (word_valid),
    .blank_in (word_blank),
    .rgb_in   (bram_rdata_in),
    .pixel_out(pixel_out),
    .luma_out (luma_out),
    .bw_out   (bw_out)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) valid_pixel_out <= 1'b0;
    else        valid_pixel_out <= word_valid;
  end

endmodule
